tile_map_editor: RTL and testbench

TILE_MAP_EDITOR -- requirements
Module: tile_map_editor

---
 rtl/tile_map_editor_if.sv | 27 ++
 rtl/tile_map_editor.sv | 153 +++++++++++++++
 tb/tb_tile_map_editor.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/tile_map_editor_if.sv
// Tile-map editor bus: raw user controls in, tile-map write port and cursor out.
interface tile_map_editor_if #(
   parameter int ADDR_W = 9,
   parameter int TILE_W = 5
);
   logic [3:0]        Buttons;
   logic [15:0]       Switches;
   logic [ADDR_W-1:0] TilesPositionAddress;
   logic [TILE_W-1:0] TilesPositionData;
   logic              TilesPositionWrite;
   logic [ADDR_W-1:0] CursorAddress;
   logic              Busy;

   // The editor drives the tile-map write port.
   modport master (
      input  Buttons, Switches,
      output TilesPositionAddress, TilesPositionData, TilesPositionWrite,
      output CursorAddress, Busy
   );

   // The tile-map memory / user side.
   modport slave (
      output Buttons, Switches,
      input  TilesPositionAddress, TilesPositionData, TilesPositionWrite,
      input  CursorAddress, Busy
   );
endinterface

// File: rtl/tile_map_editor.sv
// Tile-map editor: debounced buttons move a cursor over a COLS x ROWS grid,
// a place switch writes the selected tile under the cursor, and a clear
// switch (or reset release) sweeps zero into every map entry.
module tile_map_editor #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int COLS_LOG2       = 5,
   parameter int ROWS_LOG2       = 4
) (
   input  logic              MasterCLK,
   input  logic              Reset,
   tile_map_editor_if.master bus
);
   localparam int ADDR_W = COLS_LOG2 + ROWS_LOG2;
   localparam int NCTL   = 6;
   localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Control bit positions inside the synchronised vector.
   localparam int EV_UP    = 0;
   localparam int EV_DOWN  = 1;
   localparam int EV_LEFT  = 2;
   localparam int EV_RIGHT = 3;
   localparam int EV_PLACE = 4;
   localparam int EV_CLR   = 5;

   typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;

   logic [NCTL-1:0]            raw_s1, raw_s2;
   logic [NCTL-1:0][CNT_W-1:0] db_cnt;
   logic [NCTL-1:0]            db_level;
   logic [NCTL-1:0]            ev;

   state_t                 state, state_nxt;
   logic [ADDR_W-1:0]      clr_addr, clr_addr_nxt;
   logic [ROWS_LOG2-1:0]   row, row_nxt;
   logic [COLS_LOG2-1:0]   col, col_nxt;
   logic [ADDR_W-1:0]      wr_addr, wr_addr_nxt;
   logic [4:0]             wr_data, wr_data_nxt;
   logic                   wr_en, wr_en_nxt;
   logic                   busy, busy_nxt;

   // Switches[13:5] carry no function in this block.
   wire unused_switches = &{1'b0, bus.Switches[13:5]};

   // Two-flop synchroniser for buttons and the place/clear switches.
   always_ff @(posedge MasterCLK or negedge Reset) begin
      if (!Reset) begin
         raw_s1 <= '0;
         raw_s2 <= '0;
      end else begin
         raw_s1 <= {bus.Switches[15:14], bus.Buttons};
         raw_s2 <= raw_s1;
      end
   end

   // Per-control debounce; a level is accepted after DEBOUNCE_CYCLES
   // consecutive samples that differ from it, and a rising acceptance
   // produces a one-cycle event.
   always_ff @(posedge MasterCLK or negedge Reset) begin
      if (!Reset) begin
         db_cnt   <= '0;
         db_level <= '0;
         ev       <= '0;
      end else begin
         for (int i = 0; i < NCTL; i++) begin
            ev[i] <= 1'b0;
            if (raw_s2[i] == db_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               db_cnt[i]   <= '0;
               db_level[i] <= raw_s2[i];
               ev[i]       <= raw_s2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Editor state and registered outputs.
   always_ff @(posedge MasterCLK or negedge Reset) begin
      if (!Reset) begin
         state    <= CLEAR;
         clr_addr <= '0;
         row      <= '0;
         col      <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_en    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
         row      <= row_nxt;
         col      <= col_nxt;
         wr_addr  <= wr_addr_nxt;
         wr_data  <= wr_data_nxt;
         wr_en    <= wr_en_nxt;
         busy     <= busy_nxt;
      end
   end

   // Next-state: sweep, cursor moves and single-cycle tile writes; events
   // outside IDLE are simply dropped since they are one-cycle pulses.
   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      row_nxt      = row;
      col_nxt      = col;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      wr_en_nxt    = 1'b0;
      busy_nxt     = 1'b0;
      case (state)
         CLEAR: begin
            wr_en_nxt    = 1'b1;
            busy_nxt     = 1'b1;
            wr_addr_nxt  = clr_addr;
            wr_data_nxt  = '0;
            clr_addr_nxt = clr_addr + ADDR_W'(1);
            if (clr_addr == '1) state_nxt = IDLE;
         end
         IDLE: begin
            if (ev[EV_CLR]) begin
               state_nxt    = CLEAR;
               clr_addr_nxt = '0;
            end else if (ev[EV_PLACE]) begin
               state_nxt   = WRITE;
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = {row, col};
               wr_data_nxt = bus.Switches[4:0];
            end else begin
               if (ev[EV_UP] && !ev[EV_DOWN])         row_nxt = row - ROWS_LOG2'(1);
               else if (ev[EV_DOWN] && !ev[EV_UP])    row_nxt = row + ROWS_LOG2'(1);
               if (ev[EV_LEFT] && !ev[EV_RIGHT])      col_nxt = col - COLS_LOG2'(1);
               else if (ev[EV_RIGHT] && !ev[EV_LEFT]) col_nxt = col + COLS_LOG2'(1);
            end
         end
         WRITE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.TilesPositionAddress = wr_addr;
   assign bus.TilesPositionData    = wr_data;
   assign bus.TilesPositionWrite   = wr_en;
   assign bus.CursorAddress        = {row, col};
   assign bus.Busy                 = busy;
endmodule

// File: tb/tb_tile_map_editor.sv
// Bench for tile_map_editor with a short debounce: reset sweep, directed
// vector table, multi-cycle corner cases and randomised cursor/place traffic.
module tb_tile_map_editor;
   logic MasterCLK = 1'b0;
   logic Reset;

   always #5 MasterCLK = ~MasterCLK;

   tile_map_editor_if bus ();

   tile_map_editor #(.DEBOUNCE_CYCLES(4)) dut (
      .MasterCLK (MasterCLK),
      .Reset     (Reset),
      .bus       (bus.master)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [8:0] log_addr[$];
   logic [4:0] log_data[$];
   int         busy_cycles = 0;

   typedef struct {
      logic [3:0] btn;
      logic [1:0] sw;
      logic [4:0] tile;
      logic [8:0] exp_cur;
      int         exp_wr;
      logic [8:0] exp_waddr;
      logic [4:0] exp_wdata;
   } vec_t;

   vec_t vecs[12];

   // Record every write strobe and every Busy cycle away from the clock edge.
   always @(negedge MasterCLK) begin
      if (Reset && bus.TilesPositionWrite) begin
         log_addr.push_back(bus.TilesPositionAddress);
         log_data.push_back(bus.TilesPositionData);
      end
      if (Reset && bus.Busy) busy_cycles++;
   end

   // Whole-run guard.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge MasterCLK);
   endtask

   task automatic press(input logic [3:0] btn, input logic [1:0] sw, input logic [4:0] tile, input int hold);
      bus.Switches[4:0]   = tile;
      bus.Buttons         = btn;
      bus.Switches[15:14] = sw;
      cycles(hold);
      bus.Buttons         = '0;
      bus.Switches[15:14] = '0;
      cycles(12);
   endtask

   task automatic check_sweep(input string name, input int base);
      int bad;
      bad = 0;
      check({name, " strobe count"}, log_addr.size() - base, 512);
      for (int i = 0; i < 512; i++) begin
         if (base + i < log_addr.size()) begin
            if (log_addr[base + i] !== 9'(i) || log_data[base + i] !== 5'd0) bad++;
         end
      end
      check({name, " address order/data"}, bad, 0);
   endtask

   initial begin
      int base, busy0, bad;
      bit found;
      int row, col, up, dn, lf, rt, pl;
      logic [3:0] btn;
      logic [4:0] tile;
      logic [4:0] ref_map[512];
      logic [4:0] dut_map[512];

      // Directed vectors; cursor starts at 0 after the reset sweep.
      vecs[0]  = '{4'b0100, 2'b00, 5'h00, 9'h01F, 0, 9'h000, 5'h00}; // left wraps col
      vecs[1]  = '{4'b0001, 2'b00, 5'h00, 9'h1FF, 0, 9'h000, 5'h00}; // up wraps row
      vecs[2]  = '{4'b1000, 2'b00, 5'h00, 9'h1E0, 0, 9'h000, 5'h00}; // right wraps col
      vecs[3]  = '{4'b0010, 2'b00, 5'h00, 9'h000, 0, 9'h000, 5'h00}; // down wraps row
      vecs[4]  = '{4'b1010, 2'b00, 5'h00, 9'h021, 0, 9'h000, 5'h00}; // down+right
      vecs[5]  = '{4'b1011, 2'b00, 5'h00, 9'h022, 0, 9'h000, 5'h00}; // up+down cancel
      vecs[6]  = '{4'b1110, 2'b00, 5'h00, 9'h042, 0, 9'h000, 5'h00}; // left+right cancel
      vecs[7]  = '{4'b1000, 2'b01, 5'h13, 9'h042, 1, 9'h042, 5'h13}; // place beats right
      vecs[8]  = '{4'b1010, 2'b00, 5'h00, 9'h063, 0, 9'h000, 5'h00};
      vecs[9]  = '{4'b1010, 2'b00, 5'h00, 9'h084, 0, 9'h000, 5'h00};
      vecs[10] = '{4'b1010, 2'b00, 5'h00, 9'h0A5, 0, 9'h000, 5'h00};
      vecs[11] = '{4'b0000, 2'b01, 5'h13, 9'h0A5, 1, 9'h0A5, 5'h13}; // place at 0x0A5

      bus.Buttons  = '0;
      bus.Switches = '0;
      Reset        = 1'b0;
      cycles(3);

      // Reset values.
      check("reset cursor", bus.CursorAddress, 9'h000);
      check("reset addr", bus.TilesPositionAddress, 9'h000);
      check("reset data", bus.TilesPositionData, 5'h00);
      check("reset strobe", bus.TilesPositionWrite, 1'b0);
      check("reset busy", bus.Busy, 1'b0);

      // Reset release starts the sweep on the first edge.
      base  = log_addr.size();
      busy0 = busy_cycles;
      Reset = 1'b1;
      @(negedge MasterCLK);
      check("first strobe", bus.TilesPositionWrite, 1'b1);
      check("first addr", bus.TilesPositionAddress, 9'h000);
      check("first busy", bus.Busy, 1'b1);
      cycles(530);
      check_sweep("power-up sweep", base);
      check("sweep busy cycles", busy_cycles - busy0, 512);
      check("idle strobe low", bus.TilesPositionWrite, 1'b0);
      check("idle busy low", bus.Busy, 1'b0);

      // Table-driven vectors.
      for (int v = 0; v < 12; v++) begin
         base = log_addr.size();
         press(vecs[v].btn, vecs[v].sw, vecs[v].tile, 10);
         check($sformatf("vec%0d cursor", v), bus.CursorAddress, vecs[v].exp_cur);
         check($sformatf("vec%0d strobes", v), log_addr.size() - base, vecs[v].exp_wr);
         if (vecs[v].exp_wr > 0 && log_addr.size() > base) begin
            check($sformatf("vec%0d waddr", v), log_addr[base], vecs[v].exp_waddr);
            check($sformatf("vec%0d wdata", v), log_data[base], vecs[v].exp_wdata);
         end
      end

      // Short glitch on down is rejected.
      bus.Buttons = 4'b0010;
      cycles(3);
      bus.Buttons = 4'b0000;
      cycles(12);
      check("glitch cursor", bus.CursorAddress, 9'h0A5);

      // Clear request, then place+right during the sweep are discarded.
      base = log_addr.size();
      press(4'b0000, 2'b10, 5'h07, 10);
      check("clear busy", bus.Busy, 1'b1);
      press(4'b1000, 2'b01, 5'h07, 10);
      cycles(520);
      check_sweep("clear sweep", base);
      check("clear cursor kept", bus.CursorAddress, 9'h0A5);
      check("clear idle strobe", bus.TilesPositionWrite, 1'b0);

      // Reset asserted at sweep address 200 aborts and restarts from 0.
      bus.Switches[15:14] = 2'b10;
      found = 1'b0;
      for (int i = 0; i < 700 && !found; i++) begin
         @(negedge MasterCLK);
         if (bus.TilesPositionWrite && bus.TilesPositionAddress == 9'd200) found = 1'b1;
      end
      check("reached addr 200", found, 1'b1);
      #1 Reset = 1'b0;
      #1;
      check("async reset addr", bus.TilesPositionAddress, 9'h000);
      check("async reset strobe", bus.TilesPositionWrite, 1'b0);
      check("async reset busy", bus.Busy, 1'b0);
      check("async reset cursor", bus.CursorAddress, 9'h000);
      bus.Switches[15:14] = 2'b00;
      cycles(3);
      base  = log_addr.size();
      Reset = 1'b1;
      @(negedge MasterCLK);
      check("restart addr", bus.TilesPositionAddress, 9'h000);
      check("restart strobe", bus.TilesPositionWrite, 1'b1);
      cycles(530);
      check_sweep("restart sweep", base);

      // Randomised moves and places against the reference cursor/map model.
      row = 0;
      col = 0;
      for (int a = 0; a < 512; a++) ref_map[a] = 5'h00;
      for (int k = 0; k < 40; k++) begin
         btn  = 4'($urandom_range(0, 15));
         tile = 5'($urandom_range(0, 31));
         pl   = ($urandom_range(0, 3) == 0) ? 1 : 0;
         base = log_addr.size();
         press(btn, {1'b0, pl[0]}, tile, 10);
         if (pl == 1) begin
            ref_map[row * 32 + col] = tile;
            check($sformatf("rand%0d strobes", k), log_addr.size() - base, 1);
            if (log_addr.size() > base) begin
               check($sformatf("rand%0d waddr", k), log_addr[base], 9'(row * 32 + col));
               check($sformatf("rand%0d wdata", k), log_data[base], tile);
            end
         end else begin
            up = btn[0]; dn = btn[1]; lf = btn[2]; rt = btn[3];
            row = (row + dn - up + 16) % 16;
            col = (col + rt - lf + 32) % 32;
            check($sformatf("rand%0d strobes", k), log_addr.size() - base, 0);
         end
         check($sformatf("rand%0d cursor", k), bus.CursorAddress, 9'(row * 32 + col));
      end

      // Replay every logged write into a map and compare with the model.
      for (int a = 0; a < 512; a++) dut_map[a] = 5'h00;
      for (int j = 0; j < log_addr.size(); j++) dut_map[log_addr[j]] = log_data[j];
      bad = 0;
      for (int a = 0; a < 512; a++) if (dut_map[a] !== ref_map[a]) bad++;
      check("final tile map", bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
